// File: rtl/irq_capture_pkg.sv
// Shared CPU-side definitions for the interrupt capture block: line count,
// FSM encoding, priority helper and the manager's subroutine addresses.
package irq_capture_pkg;

  localparam int NUM_LINES = 4;
  localparam int SEL_W     = 2;

  typedef logic [1:0] irq_state_t;

  localparam irq_state_t ST_IDLE  = 2'd0;
  localparam irq_state_t ST_SERVE = 2'd1;
  localparam irq_state_t ST_GAP   = 2'd2;

  // Interrupt manager subroutine entry points, one per line.
  localparam logic [15:0] ISR_BASE_ADDR = 16'h0100;
  localparam logic [15:0] ISR_STRIDE    = 16'h0010;

  function automatic logic [15:0] isr_addr(input logic [SEL_W-1:0] line);
    return ISR_BASE_ADDR + (16'(line) * ISR_STRIDE);
  endfunction

  // Bit 0 is the highest priority, so the lowest set index wins.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_LINES-1:0] vec);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[SEL_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_capture_if.sv
// Request, mask and service-handshake signals between the CPU/peripherals
// (master) and the capture block (slave).
interface irq_capture_if;

  logic [irq_capture_pkg::NUM_LINES-1:0] irq_in;
  logic                                  mask_we;
  logic [irq_capture_pkg::NUM_LINES-1:0] mask_in;
  logic                                  fin;
  logic                                  iport1;
  logic                                  iport2;
  logic                                  iport3;
  logic                                  iport4;
  logic [irq_capture_pkg::NUM_LINES-1:0] pending;
  logic [irq_capture_pkg::NUM_LINES-1:0] ovf;
  logic                                  busy;

  modport master (
    output irq_in, mask_we, mask_in, fin,
    input  iport1, iport2, iport3, iport4, pending, ovf, busy
  );

  modport slave (
    input  irq_in, mask_we, mask_in, fin,
    output iport1, iport2, iport3, iport4, pending, ovf, busy
  );

endinterface

// File: rtl/irq_sync_edge.sv
// Per-line synchronizer with rising-edge detect on the last two stages.
// A parallel fill chain suppresses a false edge from a line already high at reset release.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] fill_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= '0;
      fill_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], irq_async};
      fill_reg <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Only trust the comparison once the last stage holds a post-reset sample.
  assign rise = fill_reg[SYNC_STAGES-1] & sync_reg[SYNC_STAGES-2] & ~sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/irq_capture.sv
// Captures asynchronous interrupt edges, latches them as pending, and presents
// one request at a time to the interrupt manager with a mandatory low gap.
module irq_capture
  import irq_capture_pkg::*;
#(
  parameter int                   SYNC_STAGES = 2,
  parameter logic [NUM_LINES-1:0] MASK_RST    = 4'b1111
) (
  input  logic          clk,
  input  logic          reset,
  irq_capture_if.slave  bus
);

  logic [NUM_LINES-1:0] edge_det;
  logic [NUM_LINES-1:0] en_edge;
  logic [NUM_LINES-1:0] clr_vec;
  logic [NUM_LINES-1:0] ovf_evt;
  logic [NUM_LINES-1:0] serve_vec;

  logic [NUM_LINES-1:0] pending_reg, pending_next;
  logic [NUM_LINES-1:0] ovf_reg, ovf_next;
  logic [NUM_LINES-1:0] mask_reg, mask_next;
  irq_state_t           state_reg, state_next;
  logic [SEL_W-1:0]     sel_reg, sel_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
      irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync_edge (
        .clk       (clk),
        .reset     (reset),
        .irq_async (bus.irq_in[gi]),
        .rise      (edge_det[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    clr_vec    = '0;
    case (state_reg)
      ST_IDLE: begin
        if (|(pending_reg & mask_reg)) begin
          sel_next   = lowest_set(pending_reg & mask_reg);
          state_next = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (bus.fin) begin
          clr_vec[sel_reg] = 1'b1;
          state_next       = ST_GAP;
        end
      end
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // A new edge on the line being retired is a fresh request, not an overflow.
  always_comb begin
    en_edge      = edge_det & mask_reg;
    ovf_evt      = en_edge & pending_reg & ~clr_vec;
    pending_next = (pending_reg & ~clr_vec) | en_edge;
    ovf_next     = (bus.mask_we ? '0 : ovf_reg) | ovf_evt;
    mask_next    = bus.mask_we ? bus.mask_in : mask_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      sel_reg     <= '0;
      pending_reg <= '0;
      ovf_reg     <= '0;
      mask_reg    <= MASK_RST;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      pending_reg <= pending_next;
      ovf_reg     <= ovf_next;
      mask_reg    <= mask_next;
    end
  end

  always_comb begin
    serve_vec = '0;
    if (state_reg == ST_SERVE) serve_vec[sel_reg] = 1'b1;
  end

  assign bus.iport1  = serve_vec[0];
  assign bus.iport2  = serve_vec[1];
  assign bus.iport3  = serve_vec[2];
  assign bus.iport4  = serve_vec[3];
  assign bus.pending = pending_reg;
  assign bus.ovf     = ovf_reg;
  assign bus.busy    = (state_reg != ST_IDLE);

endmodule

// File: doc/irq_capture.md
IRQ_CAPTURE -- requirements
Module: irq_capture

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per request line (min 2).
REQ-002 SHALL have parameter MASK_RST, default 4'b1111, meaning enable mask value after reset.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port irq_in, input, 4, meaning asynchronous peripheral request lines; bit0 highest priority.
REQ-006 SHALL have port mask_we, input, 1, meaning load mask_in and clear ovf this cycle.
REQ-007 SHALL have port mask_in, input, 4, meaning new enable mask.
REQ-008 SHALL have port fin, input, 1, meaning subroutine-return strobe from the CPU; one cycle.
REQ-009 SHALL have ports iport1..iport4, output, 1 each, meaning the one-hot level request to the interrupt manager.
REQ-010 SHALL have port pending, output, 4, meaning latched, not yet serviced requests.
REQ-011 SHALL have port ovf, output, 4, meaning sticky per-line lost-request flags.
REQ-012 SHALL have port busy, output, 1, meaning a request is being presented or serviced.

Function
REQ-013 Each irq_in bit SHALL pass through SYNC_STAGES flops; a rising edge is detected on the last two stages.
REQ-014 A detected edge on line i with mask[i]=1 SHALL set pending[i] next cycle; with mask[i]=0 it SHALL be dropped.
REQ-015 An enabled edge on line i while pending[i]=1 SHALL set ovf[i]; pending stays 1.
REQ-016 FSM states: IDLE, SERVE, GAP.
REQ-017 IDLE: if (pending & mask) != 0, register sel = lowest set index and go to SERVE; else stay.
REQ-018 SERVE: iport(sel+1)=1, all other iports 0, busy=1; stay until fin=1.
REQ-019 SERVE with fin=1: clear pending[sel], go to GAP; iports SHALL be 0 from the next cycle.
REQ-020 GAP: all iports 0 and busy=1 for exactly one cycle, then IDLE; this guarantees the manager sees one low cycle between requests.
REQ-021 Latency: an edge synchronized in cycle N SHALL produce an iport high no earlier than N+2 (pending, then IDLE->SERVE), when the FSM is idle.
REQ-022 If a new enabled edge on line sel coincides with fin in SERVE, set SHALL win: pending[sel] stays 1, and the line is re-served after GAP.
REQ-023 A higher-priority request arriving during SERVE SHALL NOT preempt; it is served after GAP.
REQ-024 mask_we during SERVE SHALL NOT abort the current service; the new mask applies to edge capture and to IDLE selection from the next cycle.
REQ-025 mask_we SHALL clear all ovf bits; a simultaneous overflow event SHALL win for its bit.
REQ-026 fin in IDLE or GAP SHALL be ignored.
REQ-027 At most one iport SHALL be high in any cycle.

Reset
REQ-028 While reset=0: synchronizer flops, pending, ovf, and sel = 0; mask = MASK_RST; FSM = IDLE; all iports and busy = 0.
REQ-029 Reset assertion mid-SERVE SHALL drop iports asynchronously and discard all pending requests.
REQ-030 After reset deasserts, an irq_in line already high SHALL NOT count as an edge.

Structure
REQ-031 FSM state encoding, the line count (4), and the priority order SHALL live in the shared CPU package, with the manager's subroutine address constants.
REQ-032 The per-line synchronizer plus edge detector SHALL be one sub-module, irq_sync_edge, instantiated four times.

Verification
REQ-033 Reset, then pulse irq_in[2] -> pending=0100; iport3=1 until fin; after fin, pending=0000 and one GAP cycle with busy=1.
REQ-034 Raise irq_in[3] and irq_in[0] in the same cycle -> iport1 is served first; iport4 is high only after fin plus GAP.
REQ-035 Load mask=1110 and pulse irq_in[0] -> pending stays 0000 and no iport asserts.
REQ-036 Give line1 two edges while it is pending -> ovf=0010; mask_we then clears ovf to 0000.
REQ-037 Edge on irq_in[1] in the same cycle as fin while serving line1 -> iport2 re-asserts after GAP.
REQ-038 Assert reset during SERVE -> iports drop at once; a held-high irq_in creates no request after release.
